// File: rtl/tile_xy_pkg.sv
// Shared types and helpers for the tile X/Y cache-line arbitration slice.
// Holds line geometry, the output-stage record and the round-robin pick function.
package tile_xy_pkg;

    localparam int LINE_W  = 528;
    localparam int LADDR_W = 37;
    localparam int LSIZE_W = 43;
    localparam int RR_MAX  = 8;

    typedef struct packed {
        logic               expun;
        logic [LSIZE_W-1:0] size;
        logic [LADDR_W-1:0] addr;
        logic [LINE_W-1:0]  data;
    } line_req_t;

    localparam line_req_t LINE_ZERO = '{
        expun: 1'b0,
        size:  {LSIZE_W{1'b0}},
        addr:  {LADDR_W{1'b0}},
        data:  {LINE_W{1'b0}}
    };

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

    // First set bit of mask at or after ptr, wrapping at n; 0 when mask is empty.
    function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] mask,
                                           input logic [2:0]        ptr,
                                           input int                n);
        logic [2:0] pick;
        logic       found;
        logic [3:0] cand;
        pick  = 3'd0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            cand  = {1'b0, ptr} + 4'(k);
            cand  = (cand >= 4'(n)) ? (cand - 4'(n)) : cand;
            pick  = ((k < n) && !found && mask[cand[2:0]]) ? cand[2:0] : pick;
            found = found | ((k < n) && mask[cand[2:0]]);
        end
        return pick;
    endfunction

endpackage

// File: rtl/tile_xy_reqmort_arb_chk.sv
// Runtime invariants of the reqmort arbiter: pointer range and one-hot pop strobe.
module tile_xy_reqmort_arb_chk #(
    parameter int NREQ = 6
) (
    input logic            clk,
    input logic            rst,
    input logic [2:0]      ptr,
    input logic [NREQ-1:0] req_ready
);

    ptr_range_a: assert property (@(posedge clk) disable iff (rst) (int'(ptr) < NREQ));
    pop_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

endmodule

// File: rtl/tile_xy_rr_pick.sv
// Combinational round-robin picker: first requester in mask at or after ptr.
module tile_xy_rr_pick
    import tile_xy_pkg::*;
#(
    parameter int NREQ = 6
) (
    input  logic [NREQ-1:0] mask,
    input  logic [2:0]      ptr,
    output logic [2:0]      idx,
    output logic            any
);

    logic [RR_MAX-1:0] mask_ext;

    assign mask_ext = RR_MAX'(mask);
    assign idx      = rr_pick(mask_ext, ptr, NREQ);
    assign any      = |mask;

endmodule

// File: rtl/tile_xy_reqmort_arb.sv
// Reqmort port arbiter: forced / expunge round-robin / normal round-robin grant into
// one registered output stage. Define TILE_ARB_STATS_EN to add grant/stall counters.
module tile_xy_reqmort_arb
    import tile_xy_pkg::*;
#(
    parameter int NREQ    = 6,
    parameter int DATA_W  = LINE_W,
    parameter int ADDR_W  = LADDR_W,
    parameter int SIZE_W  = LSIZE_W,
    parameter int MAXWAIT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_expun,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*SIZE_W-1:0] req_size,
    output logic [NREQ-1:0]        req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [SIZE_W-1:0]      out_size,
    output logic                   out_expun,
    output logic [2:0]             out_src,
    output logic                   starve_hit
`ifdef TILE_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]     grant_cnt,
    output logic [15:0]            stall_cnt
`endif
);

    localparam int               WCNT_W   = $clog2(MAXWAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_SAT = WCNT_W'(MAXWAIT);
    localparam logic [2:0]       LAST_IDX = 3'(NREQ - 1);

    stage_state_t      state_r;
    line_req_t         stage_r;
    logic [2:0]        src_r;
    logic [2:0]        ptr_r;
    logic [WCNT_W-1:0] wait_cnt_r [NREQ];

    logic              slot_free_s;
    logic              grant_en_s;
    logic [NREQ-1:0]   forced_mask_s;
    logic              forced_s;
    logic [2:0]        forced_idx_s;
    logic [2:0]        exp_idx_s;
    logic              exp_any_s;
    logic [2:0]        norm_idx_s;
    logic              norm_any_s;
    logic [2:0]        grant_idx_s;
    line_req_t         grant_line_s;

    tile_xy_rr_pick #(.NREQ(NREQ)) u_pick_exp (
        .mask (req_valid & req_expun),
        .ptr  (ptr_r),
        .idx  (exp_idx_s),
        .any  (exp_any_s)
    );

    tile_xy_rr_pick #(.NREQ(NREQ)) u_pick_all (
        .mask (req_valid),
        .ptr  (ptr_r),
        .idx  (norm_idx_s),
        .any  (norm_any_s)
    );

    assign out_valid   = (state_r == ST_FULL);
    assign slot_free_s = !out_valid || out_ready;
    // rst gates the grant so no pop strobe escapes while requesters are being reset.
    assign grant_en_s  = !rst && slot_free_s && norm_any_s;
    assign req_ready   = grant_en_s ? (NREQ'(1'b1) << grant_idx_s) : {NREQ{1'b0}};
    assign starve_hit  = grant_en_s && forced_s;

    // Requesters whose wait counter has saturated, lowest index wins.
    always_comb begin
        forced_mask_s = {NREQ{1'b0}};
        forced_s      = 1'b0;
        forced_idx_s  = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            forced_mask_s[i] = req_valid[i] && (wait_cnt_r[i] == WAIT_SAT);
            forced_idx_s     = (forced_mask_s[i] && !forced_s) ? 3'(i) : forced_idx_s;
            forced_s         = forced_s | forced_mask_s[i];
        end
    end

    // Priority select and payload mux for the winning requester.
    always_comb begin
        if (forced_s) begin
            grant_idx_s = forced_idx_s;
        end else if (exp_any_s) begin
            grant_idx_s = exp_idx_s;
        end else begin
            grant_idx_s = norm_idx_s;
        end
        grant_line_s       = LINE_ZERO;
        grant_line_s.expun = req_expun[grant_idx_s];
        grant_line_s.size  = req_size[int'(grant_idx_s)*SIZE_W +: SIZE_W];
        grant_line_s.addr  = req_addr[int'(grant_idx_s)*ADDR_W +: ADDR_W];
        grant_line_s.data  = req_data[int'(grant_idx_s)*DATA_W +: DATA_W];
    end

    // Output stage FSM, payload capture and round-robin pointer advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
            stage_r <= LINE_ZERO;
            src_r   <= 3'd0;
            ptr_r   <= 3'd0;
        end else begin
            case (state_r)
                ST_EMPTY: state_r <= grant_en_s ? ST_FULL : ST_EMPTY;
                ST_FULL:  state_r <= (out_ready && !grant_en_s) ? ST_EMPTY : ST_FULL;
                default:  state_r <= ST_EMPTY;
            endcase
            if (grant_en_s) begin
                stage_r <= grant_line_s;
                src_r   <= grant_idx_s;
                ptr_r   <= (grant_idx_s == LAST_IDX) ? 3'd0 : (grant_idx_s + 3'd1);
            end
        end
    end

    // Saturating per-requester wait counters feeding the starvation override.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                wait_cnt_r[i] <= {WCNT_W{1'b0}};
            end else if (!req_valid[i] || (grant_en_s && (grant_idx_s == 3'(i)))) begin
                wait_cnt_r[i] <= {WCNT_W{1'b0}};
            end else if (wait_cnt_r[i] != WAIT_SAT) begin
                wait_cnt_r[i] <= wait_cnt_r[i] + WCNT_W'(1'b1);
            end else begin
                wait_cnt_r[i] <= wait_cnt_r[i];
            end
        end
    end

    assign out_data  = stage_r.data;
    assign out_addr  = stage_r.addr;
    assign out_size  = stage_r.size;
    assign out_expun = stage_r.expun;
    assign out_src   = src_r;

`ifdef TILE_ARB_STATS_EN
    logic [15:0] grant_cnt_r [NREQ];
    logic [15:0] stall_cnt_r;

    // Saturating grant and back-pressure statistics.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                grant_cnt_r[i] <= 16'd0;
            end else if (grant_en_s && (grant_idx_s == 3'(i)) && (grant_cnt_r[i] != 16'hFFFF)) begin
                grant_cnt_r[i] <= grant_cnt_r[i] + 16'd1;
            end
        end
        if (rst) begin
            stall_cnt_r <= 16'd0;
        end else if (out_valid && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    // Flatten the per-requester counters onto the port.
    always_comb begin
        grant_cnt = {(NREQ*16){1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt[i*16 +: 16] = grant_cnt_r[i];
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    tile_xy_reqmort_arb_chk #(.NREQ(NREQ)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .ptr       (ptr_r),
        .req_ready (req_ready)
    );

endmodule

// File: tb/tb_tile_xy_reqmort_arb.sv
// Table-driven bench for tile_xy_reqmort_arb with a queue scoreboard on the output stage.
module tb_tile_xy_reqmort_arb;
    import tile_xy_pkg::*;

    localparam int NREQ = 6;
    localparam int DW   = LINE_W;
    localparam int AW   = LADDR_W;
    localparam int SW   = LSIZE_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_expun;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*SW-1:0]   req_size;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [AW-1:0]        out_addr;
    logic [SW-1:0]        out_size;
    logic                 out_expun;
    logic [2:0]           out_src;
    logic                 starve_hit;
`ifdef TILE_ARB_STATS_EN
    logic [NREQ*16-1:0]   grant_cnt;
    logic [15:0]          stall_cnt;
`endif

    tile_xy_reqmort_arb dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_expun  (req_expun),
        .req_data   (req_data),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_size   (out_size),
        .out_expun  (out_expun),
        .out_src    (out_src),
        .starve_hit (starve_hit)
`ifdef TILE_ARB_STATS_EN
        ,
        .grant_cnt  (grant_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    typedef struct {
        logic       rst;
        logic [5:0] valid;
        logic [5:0] expun;
        logic       ordy;
        logic [5:0] exp_ready;
        logic       exp_starve;
        logic       exp_ovalid;
        logic [2:0] exp_src;
    } row_t;

    typedef struct {
        logic [2:0]    src;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic [SW-1:0] size;
        logic          expun;
    } line_t;

    row_t  rows[$];
    line_t sb[$];
    int    checks;
    int    failures;
    int    cur_row;
    int    seq [NREQ];
    logic       b_ovalid;
    logic [2:0] b_src;

    function automatic int oh_idx(input logic [5:0] v);
        for (int i = 0; i < 6; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [DW-1:0] mk_data(input int i, input int s);
        logic [DW-1:0] d;
        d = '0;
        d[31:0]      = {8'(i), 24'(s)};
        d[DW-1 -: 32] = ~{8'(i), 24'(s)};
        return d;
    endfunction

    function automatic logic [AW-1:0] mk_addr(input int i, input int s);
        return AW'(i * 4096 + s + 77);
    endfunction

    function automatic logic [SW-1:0] mk_size(input int i, input int s);
        return SW'((i << 20) | (s * 3 + 1));
    endfunction

    task automatic drive_payload();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DW +: DW] = mk_data(i, seq[i]);
            req_addr[i*AW +: AW] = mk_addr(i, seq[i]);
            req_size[i*SW +: SW] = mk_size(i, seq[i]);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h exp=%0h", nm, cur_row, got, exp);
        end
    endtask

    // Expected out_valid/out_src follow the stage's load/hold/drain rules.
    task automatic add_row(input logic r, input logic [5:0] v, input logic [5:0] e,
                           input logic o, input logic [5:0] er, input logic es);
        row_t x;
        x.rst = r; x.valid = v; x.expun = e; x.ordy = o;
        x.exp_ready = er; x.exp_starve = es;
        x.exp_ovalid = b_ovalid; x.exp_src = b_src;
        rows.push_back(x);
        if (r) begin
            b_ovalid = 1'b0;
            b_src    = 3'd0;
        end else if (er != 6'd0) begin
            b_ovalid = 1'b1;
            b_src    = 3'(oh_idx(er));
        end else if (o) begin
            b_ovalid = 1'b0;
        end
    endtask

    initial begin
        row_t  r;
        line_t l;
        int    gi;
        checks = 0; failures = 0; cur_row = 0;
        b_ovalid = 1'b0; b_src = 3'd0;
        for (int i = 0; i < NREQ; i++) seq[i] = 0;
        rst = 1'b1; req_valid = '0; req_expun = '0; out_ready = 1'b0;
        drive_payload();
        repeat (2) @(posedge clk);

        // reset, then alternating grants 0,2
        add_row(1'b1, 6'b000101, 6'b000000, 1'b1, 6'b000000, 1'b0);
        add_row(1'b0, 6'b000101, 6'b000000, 1'b1, 6'b000001, 1'b0);
        add_row(1'b0, 6'b000101, 6'b000000, 1'b1, 6'b000100, 1'b0);
        add_row(1'b0, 6'b000101, 6'b000000, 1'b1, 6'b000001, 1'b0);
        add_row(1'b0, 6'b000101, 6'b000000, 1'b1, 6'b000100, 1'b0);
        // reset while stage is held; pointer returns to 0
        add_row(1'b1, 6'b000000, 6'b000000, 1'b0, 6'b000000, 1'b0);
        add_row(1'b0, 6'b111111, 6'b000000, 1'b1, 6'b000001, 1'b0);
        // expunge priority, then round-robin over the rest
        add_row(1'b0, 6'b111111, 6'b010000, 1'b1, 6'b010000, 1'b0);
        add_row(1'b0, 6'b101111, 6'b000000, 1'b1, 6'b100000, 1'b0);
        add_row(1'b0, 6'b101111, 6'b000000, 1'b1, 6'b000001, 1'b0);
        add_row(1'b0, 6'b101111, 6'b000000, 1'b1, 6'b000010, 1'b0);
        add_row(1'b0, 6'b101111, 6'b000000, 1'b1, 6'b000100, 1'b0);
        add_row(1'b0, 6'b101111, 6'b000000, 1'b1, 6'b001000, 1'b0);
        // five cycles of back-pressure, then release
        for (int k = 0; k < 5; k++) add_row(1'b0, 6'b000011, 6'b000000, 1'b0, 6'b000000, 1'b0);
        add_row(1'b0, 6'b000011, 6'b000000, 1'b1, 6'b000001, 1'b0);
        add_row(1'b0, 6'b000011, 6'b000000, 1'b1, 6'b000010, 1'b0);
        add_row(1'b0, 6'b000000, 6'b000000, 1'b1, 6'b000000, 1'b0);
        add_row(1'b0, 6'b000000, 6'b000000, 1'b1, 6'b000000, 1'b0);
        // requester 5 starved by continuous expunges from 0
        for (int k = 0; k < 15; k++) add_row(1'b0, 6'b100001, 6'b000001, 1'b1, 6'b000001, 1'b0);
        add_row(1'b0, 6'b100001, 6'b000001, 1'b1, 6'b100000, 1'b1);
        add_row(1'b0, 6'b100001, 6'b000001, 1'b1, 6'b000001, 1'b0);
        add_row(1'b0, 6'b000000, 6'b000000, 1'b1, 6'b000000, 1'b0);
        add_row(1'b0, 6'b000000, 6'b000000, 1'b1, 6'b000000, 1'b0);
        // two simultaneous forced candidates: 1 then 2
        for (int k = 0; k < 15; k++) add_row(1'b0, 6'b000111, 6'b000001, 1'b1, 6'b000001, 1'b0);
        add_row(1'b0, 6'b000111, 6'b000001, 1'b1, 6'b000010, 1'b1);
        add_row(1'b0, 6'b000111, 6'b000001, 1'b1, 6'b000100, 1'b1);
        add_row(1'b0, 6'b000111, 6'b000001, 1'b1, 6'b000001, 1'b0);
        add_row(1'b0, 6'b000000, 6'b000000, 1'b1, 6'b000000, 1'b0);
        add_row(1'b0, 6'b000000, 6'b000000, 1'b1, 6'b000000, 1'b0);

        for (int n = 0; n < rows.size(); n++) begin
            r = rows[n];
            cur_row = n;
            #1;
            rst = r.rst; req_valid = r.valid; req_expun = r.expun; out_ready = r.ordy;
            drive_payload();
            @(negedge clk);
            chk("req_ready", 64'(req_ready), 64'(r.exp_ready));
            chk("starve_hit", 64'(starve_hit), 64'(r.exp_starve));
            chk("out_valid", 64'(out_valid), 64'(r.exp_ovalid));
            if (r.exp_ovalid) chk("out_src", 64'(out_src), 64'(r.exp_src));
            if (r.exp_ready != 6'd0) begin
                gi = oh_idx(r.exp_ready);
                l.src = 3'(gi); l.data = mk_data(gi, seq[gi]); l.addr = mk_addr(gi, seq[gi]);
                l.size = mk_size(gi, seq[gi]); l.expun = r.expun[gi];
                sb.push_back(l);
            end
            if (r.exp_ovalid && r.ordy) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_empty row=%0d got=accept exp=no_line", n);
                end else begin
                    l = sb.pop_front();
                    chk("sb_src", 64'(out_src), 64'(l.src));
                    chk("sb_addr", 64'(out_addr), 64'(l.addr));
                    chk("sb_size", 64'(out_size), 64'(l.size));
                    chk("sb_expun", 64'(out_expun), 64'(l.expun));
                    checks++;
                    if (out_data !== l.data) begin
                        failures++;
                        $display("FAIL sb_data row=%0d got=%h exp=%h", n, out_data[31:0], l.data[31:0]);
                    end
                end
            end
            @(posedge clk);
            if (r.rst) sb.delete();
            else if (r.exp_ready != 6'd0) seq[oh_idx(r.exp_ready)]++;
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);

`ifdef TILE_ARB_STATS_EN
        // 10 grants to requester 3 with 4 stalled cycles in the middle
        #1;
        rst = 1'b1; req_valid = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 6'b001000; req_expun = '0;
        for (int c = 0; c < 14; c++) begin
            out_ready = (c < 6) || (c >= 10);
            @(posedge clk);
            #1;
        end
        req_valid = '0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("grant_cnt3", 64'(grant_cnt[3*16 +: 16]), 64'd10);
        chk("grant_cnt0", 64'(grant_cnt[0 +: 16]), 64'd0);
        chk("stall_cnt", 64'(stall_cnt), 64'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
